// File: rtl/welcome_menu_ctrl.sv
// Welcome-screen menu controller: debounced buttons drive a
// CHOICE1/CHOICE2/ACK/PLAY screen FSM with a cursor-blink phase.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   btn_up/down/enter     raw asynchronous buttons (active-high)
//   frame_tick            one-cycle pulse per video frame
//   state[1:0]            00 CHOICE1, 01 CHOICE2, 10 ACK, 11 PLAY
//   start_game            one-cycle pulse on entry to PLAY
//   blink                 cursor-blink phase for the menu renderer

module welcome_menu_ctrl #(
    parameter int DB_CYCLES    = 50000,
    parameter int ACK_FRAMES   = 600,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       frame_tick,
    output logic [1:0] state,
    output logic       start_game,
    output logic       blink
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int AKW = (ACK_FRAMES > 2) ? $clog2(ACK_FRAMES) : 1;
    localparam int BLW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [AKW-1:0] AK_LAST = AKW'(ACK_FRAMES - 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_FRAMES - 1);

    localparam logic [1:0] ST_CHOICE1 = 2'b00;
    localparam logic [1:0] ST_CHOICE2 = 2'b01;
    localparam logic [1:0] ST_ACK     = 2'b10;
    localparam logic [1:0] ST_PLAY    = 2'b11;

    // Button vectors: bit 0 up, bit 1 down, bit 2 enter.
    logic [2:0]     w_btn;
    logic [2:0]     r_sync1;
    logic [2:0]     r_sync2;
    logic [2:0]     r_db;
    logic [2:0]     r_db_d;
    logic [2:0]     w_ev;
    logic [DBW-1:0] r_db_cnt [3];

    logic [1:0]     r_state;
    logic [1:0]     w_next;
    logic [AKW-1:0] r_ack_cnt;
    logic [BLW-1:0] r_bl_cnt;
    logic           r_start;
    logic           r_blink;

    logic w_up;
    logic w_dn;
    logic w_ent;
    logic w_ack_done;

    assign w_btn = {btn_enter, btn_down, btn_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounced level flips only after DB_CYCLES consecutive
    // cycles of disagreement with the synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db   <= '0;
            r_db_d <= '0;
            for (int k = 0; k < 3; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_db_d <= r_db;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_db[k]     <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DBW'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level only; release is silent.
    assign w_ev  = r_db & ~r_db_d;
    assign w_up  = w_ev[0];
    assign w_dn  = w_ev[1];
    assign w_ent = w_ev[2];

    assign w_ack_done = frame_tick & (r_ack_cnt == AK_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CHOICE1: begin
                if (w_ent) begin
                    w_next = ST_PLAY;
                end else if (w_dn && !w_up) begin
                    w_next = ST_CHOICE2;
                end
            end
            ST_CHOICE2: begin
                if (w_ent) begin
                    w_next = ST_ACK;
                end else if (w_up && !w_dn) begin
                    w_next = ST_CHOICE1;
                end
            end
            ST_ACK: begin
                if (w_ent || w_ack_done) begin
                    w_next = ST_CHOICE2;
                end
            end
            default: begin
                w_next = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CHOICE1;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == ST_PLAY) && (r_state != ST_PLAY);
        end
    end

    // ACK frame counter runs only while ACK persists; any entry
    // into ACK starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_cnt <= '0;
        end else if (r_state == ST_ACK && w_next == ST_ACK) begin
            if (frame_tick) begin
                r_ack_cnt <= r_ack_cnt + AKW'(1);
            end
        end else begin
            r_ack_cnt <= '0;
        end
    end

    // Blink follows the state being entered: off in ACK/PLAY,
    // restarted visible on entering a menu screen, else free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink  <= 1'b1;
            r_bl_cnt <= '0;
        end else if (w_next[1]) begin
            r_blink  <= 1'b0;
            r_bl_cnt <= '0;
        end else if (w_next != r_state) begin
            r_blink  <= 1'b1;
            r_bl_cnt <= '0;
        end else if (frame_tick) begin
            if (r_bl_cnt == BL_LAST) begin
                r_blink  <= ~r_blink;
                r_bl_cnt <= '0;
            end else begin
                r_bl_cnt <= r_bl_cnt + BLW'(1);
            end
        end
    end

    assign state      = r_state;
    assign start_game = r_start;
    assign blink      = r_blink;

endmodule

// File: tb/tb_welcome_menu_ctrl.sv
// Bench for welcome_menu_ctrl: directed scenarios plus random
// traffic checked against a behavioural screen/debounce model.

module tb_welcome_menu_ctrl;

    localparam int DB   = 4;
    localparam int ACKF = 3;
    localparam int BLF  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_enter = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] state;
    logic       start_game;
    logic       blink;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    welcome_menu_ctrl #(
        .DB_CYCLES   (DB),
        .ACK_FRAMES  (ACKF),
        .BLINK_FRAMES(BLF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_enter (btn_enter),
        .frame_tick(frame_tick),
        .state     (state),
        .start_game(start_game),
        .blink     (blink)
    );

    // Reference model. Screens: 0 CHOICE1, 1 CHOICE2, 2 ACK, 3 PLAY.
    // Button index: 0 up, 1 down, 2 enter.
    bit [2:0] m_s1, m_s2, m_db, m_dbp;
    int       m_run [3];
    int       m_scr, m_ack, m_bc;
    bit       m_start, m_blink;

    task m_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
        for (int k = 0; k < 3; k++) m_run[k] = 0;
        m_scr = 0; m_ack = 0; m_bc = 0;
        m_start = 1'b0; m_blink = 1'b1;
    endtask

    task m_step(input bit u, input bit d, input bit e, input bit t);
        bit [2:0] raw;
        bit [2:0] ev;
        int       nxt;
        raw = {e, d, u};
        ev  = m_db & ~m_dbp;
        nxt = m_scr;
        if (m_scr == 0) begin
            if (ev[2]) nxt = 3;
            else if (ev[1] && !ev[0]) nxt = 1;
        end else if (m_scr == 1) begin
            if (ev[2]) nxt = 2;
            else if (ev[0] && !ev[1]) nxt = 0;
        end else if (m_scr == 2) begin
            if (ev[2] || (t && m_ack + 1 == ACKF)) nxt = 1;
        end
        m_start = (nxt == 3) && (m_scr != 3);
        if (nxt >= 2) begin
            m_blink = 1'b0; m_bc = 0;
        end else if (nxt != m_scr) begin
            m_blink = 1'b1; m_bc = 0;
        end else if (t) begin
            m_bc++;
            if (m_bc == BLF) begin
                m_blink = !m_blink; m_bc = 0;
            end
        end
        m_ack = (nxt == 2 && m_scr == 2) ? m_ack + (t ? 1 : 0) : 0;
        m_scr = nxt;
        m_dbp = m_db;
        for (int k = 0; k < 3; k++) begin
            if (m_s2[k] != m_db[k]) begin
                m_run[k]++;
                if (m_run[k] == DB) begin
                    m_db[k] = m_s2[k]; m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // Drive one clock cycle of inputs; returns at the following negedge.
    task cycle(input bit u, input bit d, input bit e, input bit t);
        btn_up = u; btn_down = d; btn_enter = e; frame_tick = t;
        @(posedge clk);
        m_step(u, d, e, t);
        @(negedge clk);
    endtask

    task hold_reset(input bit u, input bit d, input bit e);
        rst_n = 1'b0;
        btn_up = u; btn_down = d; btn_enter = e; frame_tick = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn_up = 1; btn_down = 1; btn_enter = 1;
        m_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({state, start_game, blink} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_values: got %b want 0001", {state, start_game, blink});
        end
        btn_up = 0; btn_down = 0; btn_enter = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if ({state, start_game, blink} !== {2'(m_scr), m_start, m_blink}
                || state !== 2'b00) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", i,
                         {state, start_game, blink}, {2'(m_scr), m_start, m_blink});
            end
        end
    endtask

    task test_glitch();
        for (int i = 0; i < 13; i++) begin
            cycle(0, i < 3, 0, 0);
            checks++;
            if (state !== 2'b00 || {state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL glitch cyc %0d: got state %b want 00", i, state);
            end
        end
    endtask

    task test_down_hold();
        int moves;
        logic [1:0] prev;
        moves = 0;
        prev = state;
        for (int k = 1; k <= 18; k++) begin
            cycle(0, k <= 10, 0, 0);
            if (prev == 2'b00 && state == 2'b01) moves++;
            prev = state;
            checks++;
            if (state !== ((k >= 7) ? 2'b01 : 2'b00)
                || {state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL down_hold k=%0d: got state %b want %b", k, state,
                         (k >= 7) ? 2'b01 : 2'b00);
            end
        end
        checks++;
        if (moves != 1) begin
            errors++;
            $display("FAIL down_once: got %0d moves want 1", moves);
        end
    endtask

    task test_ack_timeout();
        for (int k = 1; k <= 16; k++) begin
            cycle(0, 0, k <= 8, 0);
            checks++;
            if (state !== ((k >= 7) ? 2'b10 : 2'b01)
                || {state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL ack_enter k=%0d: got state %b", k, state);
            end
        end
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 1);
            checks++;
            if (state !== ((k == 3) ? 2'b01 : 2'b10)
                || {state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL ack_timeout tick %0d: got state %b want %b", k, state,
                         (k == 3) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task test_play();
        int starts;
        starts = 0;
        hold_reset(0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cycle(0, 0, k <= 8, 0);
            if (start_game === 1'b1) starts++;
            checks++;
            if ({state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL play_enter k=%0d: got %b want %b", k,
                         {state, start_game, blink}, {2'(m_scr), m_start, m_blink});
            end
        end
        for (int k = 0; k < 48; k++) begin
            cycle((k % 16) < 8 && k < 16, (k % 16) < 8 && k >= 16 && k < 32,
                  (k % 16) < 8 && k >= 32, k % 3 == 0);
            if (start_game === 1'b1) starts++;
            checks++;
            if (state !== 2'b11 || start_game !== 1'b0 || blink !== 1'b0) begin
                errors++;
                $display("FAIL play_terminal k=%0d: got %b want 1100", k,
                         {state, start_game, blink});
            end
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL start_pulse: got %0d pulses want 1", starts);
        end
    endtask

    task test_simultaneous();
        hold_reset(0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cycle(k <= 8, k <= 8, 0, 0);
            checks++;
            if (state !== 2'b00 || {state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL up_down_same k=%0d: got state %b want 00", k, state);
            end
        end
        for (int k = 1; k <= 8; k++) cycle(0, 1, 1, 0);
        checks++;
        if (state !== 2'b11) begin
            errors++;
            $display("FAIL enter_down_same: got state %b want 11", state);
        end
    endtask

    task test_blink();
        hold_reset(0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 0, 0, 1);
            checks++;
            if (blink !== (((k / 2) % 2) == 0) || state !== 2'b00) begin
                errors++;
                $display("FAIL blink_toggle tick %0d: got %b want %b", k, blink,
                         ((k / 2) % 2) == 0);
            end
        end
        for (int k = 1; k <= 7; k++) cycle(0, 1, 0, 0);
        checks++;
        if (state !== 2'b01 || blink !== 1'b1) begin
            errors++;
            $display("FAIL blink_move: got state %b blink %b want 01 1", state, blink);
        end
    endtask

    task test_reset_in_ack();
        hold_reset(0, 0, 0);
        for (int k = 0; k < 16; k++) cycle(0, k < 8, 0, 0);
        for (int k = 0; k < 16; k++) cycle(0, 0, k < 8, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        checks++;
        if (state !== 2'b10 || m_ack != 2) begin
            errors++;
            $display("FAIL ack_setup: got state %b want 10", state);
        end
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({state, start_game, blink} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_in_ack: got %b want 0001", {state, start_game, blink});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (state !== 2'b00 || {state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL after_reset k=%0d: got %b", k, {state, start_game, blink});
            end
        end
    endtask

    task test_held_reset();
        hold_reset(0, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 1, 0, 0);
            checks++;
            if (state !== ((k >= 7) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL held_release k=%0d: got state %b want %b", k, state,
                         (k >= 7) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task test_random();
        bit u, d, e, t;
        u = 0; d = 0; e = 0;
        hold_reset(0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                m_reset();
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) u = !u;
            if ($urandom_range(0, 5) == 0) d = !d;
            if ($urandom_range(0, 39) == 0) e = !e;
            t = ($urandom_range(0, 2) == 0);
            cycle(u, d, e, t);
            checks++;
            if ({state, start_game, blink} !== {2'(m_scr), m_start, m_blink}) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", i,
                         {state, start_game, blink}, {2'(m_scr), m_start, m_blink});
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_glitch();
        test_down_hold();
        test_ack_timeout();
        test_play();
        test_simultaneous();
        test_blink();
        test_reset_in_ack();
        test_held_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
